// File: rtl/uart_io_nios2_qsys_oci_dct_ctrl.sv
// OCI data-capture-trace sequencer: packs 3-bit trace slots into a frame, writes
// full or flushed frames to trace memory, and runs the end-of-capture handshake.
module uart_io_nios2_qsys_oci_dct_ctrl #(
    parameter int SLOT_W    = 3,
    parameter int NUM_SLOTS = 10,
    parameter int CNT_W     = 4,
    parameter int TM_AW     = 7
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              trc_on,
    input  logic                              slot_valid,
    input  logic [SLOT_W-1:0]                 slot_data,
    output logic                              slot_ready,
    input  logic                              flush_req,
    input  logic                              end_req,
    output logic [SLOT_W*NUM_SLOTS-1:0]       dct_buffer,
    output logic [CNT_W-1:0]                  dct_count,
    output logic                              tm_wr_valid,
    output logic [CNT_W+SLOT_W*NUM_SLOTS-1:0] tm_wr_data,
    output logic [TM_AW-1:0]                  tm_wr_addr,
    input  logic                              tm_wr_ready,
    output logic                              tm_wrap,
    output logic                              test_ending,
    output logic                              test_has_ended,
    output logic [1:0]                        dbg_state
);

    localparam int BUF_W = SLOT_W * NUM_SLOTS;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_SLOTS);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        EMIT    = 2'd1,
        ENDED   = 2'd2
    } state_t;

    state_t           state_q;
    logic [BUF_W-1:0] buf_q;
    logic [CNT_W-1:0] cnt_q;
    logic [TM_AW-1:0] addr_q;
    logic             wrap_q;
    logic             end_pend_q;

    logic             accept;
    logic [BUF_W-1:0] buf_d;
    logic [CNT_W-1:0] cnt_d;

    // Both ports transfer on a cycle where valid & ready are high at the rising edge;
    // once tm_wr_valid is raised it, tm_wr_data and tm_wr_addr hold until that transfer.
    assign slot_ready = ~reset & (state_q == COLLECT) & trc_on & ~end_pend_q;
    assign accept     = slot_valid & slot_ready;
    assign buf_d      = accept ? {buf_q[BUF_W-SLOT_W-1:0], slot_data} : buf_q;
    assign cnt_d      = cnt_q + {{(CNT_W-1){1'b0}}, accept};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= COLLECT;
            buf_q      <= '0;
            cnt_q      <= '0;
            addr_q     <= '0;
            wrap_q     <= 1'b0;
            end_pend_q <= 1'b0;
        end else begin
            if (end_req && state_q != ENDED) end_pend_q <= 1'b1;
            case (state_q)
                COLLECT: begin
                    buf_q <= buf_d;
                    cnt_q <= cnt_d;
                    // The count checked includes a slot accepted in this same cycle.
                    if ((accept && cnt_d == FULL_CNT) || (flush_req && cnt_d != '0))
                        state_q <= EMIT;
                    else if (end_pend_q)
                        state_q <= (cnt_d != '0) ? EMIT : ENDED;
                end
                EMIT: begin
                    if (tm_wr_ready) begin
                        buf_q  <= '0;
                        cnt_q  <= '0;
                        addr_q <= addr_q + TM_AW'(1);
                        if (addr_q == '1) wrap_q <= 1'b1;
                        state_q <= end_pend_q ? ENDED : COLLECT;
                    end
                end
                ENDED:   state_q <= ENDED;
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign dct_buffer     = buf_q;
    assign dct_count      = cnt_q;
    assign tm_wr_valid    = (state_q == EMIT);
    assign tm_wr_data     = {cnt_q, buf_q};
    assign tm_wr_addr     = addr_q;
    assign tm_wrap        = wrap_q;
    assign test_ending    = end_pend_q;
    assign test_has_ended = (state_q == ENDED);
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_uart_io_nios2_qsys_oci_dct_ctrl.sv
// Directed bench for the DCT sequencer: a per-cycle vector table for framing,
// flush and backpressure, then hand-written end, reset and address-wrap sequences.
module tb_uart_io_nios2_qsys_oci_dct_ctrl;

    logic        clk;
    logic        reset;
    logic        trc_on;
    logic        slot_valid;
    logic [2:0]  slot_data;
    logic        slot_ready;
    logic        flush_req;
    logic        end_req;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        tm_wr_valid;
    logic [33:0] tm_wr_data;
    logic [6:0]  tm_wr_addr;
    logic        tm_wr_ready;
    logic        tm_wrap;
    logic        test_ending;
    logic        test_has_ended;
    logic [1:0]  dbg_state;

    int n_tests;
    int n_fail;

    uart_io_nios2_qsys_oci_dct_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .trc_on        (trc_on),
        .slot_valid    (slot_valid),
        .slot_data     (slot_data),
        .slot_ready    (slot_ready),
        .flush_req     (flush_req),
        .end_req       (end_req),
        .dct_buffer    (dct_buffer),
        .dct_count     (dct_count),
        .tm_wr_valid   (tm_wr_valid),
        .tm_wr_data    (tm_wr_data),
        .tm_wr_addr    (tm_wr_addr),
        .tm_wr_ready   (tm_wr_ready),
        .tm_wrap       (tm_wrap),
        .test_ending   (test_ending),
        .test_has_ended(test_has_ended),
        .dbg_state     (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        trc;
        logic        sv;
        logic [2:0]  sd;
        logic        fl;
        logic        rdy;
        logic        e_sr;
        logic        e_valid;
        logic [3:0]  e_cnt;
        logic [29:0] e_buf;
        logic [6:0]  e_addr;
    } vec_t;

    vec_t vecs[26];

    function automatic vec_t mk(logic trc, logic sv, logic [2:0] sd, logic fl, logic rdy,
                                logic e_sr, logic e_valid, logic [3:0] e_cnt,
                                logic [29:0] e_buf, logic [6:0] e_addr);
        vec_t v;
        v.trc = trc; v.sv = sv; v.sd = sd; v.fl = fl; v.rdy = rdy;
        v.e_sr = e_sr; v.e_valid = e_valid; v.e_cnt = e_cnt; v.e_buf = e_buf; v.e_addr = e_addr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 64'(slot_ready), 64'd0);
        chk({tag, "_buf"}, 64'(dct_buffer), 64'd0);
        chk({tag, "_cnt"}, 64'(dct_count), 64'd0);
        chk({tag, "_valid"}, 64'(tm_wr_valid), 64'd0);
        chk({tag, "_data"}, 64'(tm_wr_data), 64'd0);
        chk({tag, "_addr"}, 64'(tm_wr_addr), 64'd0);
        chk({tag, "_wrap"}, 64'(tm_wrap), 64'd0);
        chk({tag, "_ending"}, 64'(test_ending), 64'd0);
        chk({tag, "_ended"}, 64'(test_has_ended), 64'd0);
        chk({tag, "_state"}, 64'(dbg_state), 64'd0);
    endtask

    // Asserts reset between edges, checks outputs immediately, releases after the next edge.
    task automatic async_reset(input string tag);
        slot_valid = 1'b0; flush_req = 1'b0; end_req = 1'b0;
        #2 reset = 1'b1;
        #1 chk_all_zero(tag);
        tick();
        reset = 1'b0;
    endtask

    // Feeds ten back-to-back slots starting at base; returns just after the 10th accept edge.
    task automatic send_frame(input logic [2:0] base, input logic rdy);
        logic [2:0] d;
        trc_on = 1'b1;
        tm_wr_ready = rdy;
        d = base;
        for (int k = 0; k < 10; k++) begin
            slot_valid = 1'b1;
            slot_data = d;
            d = d + 3'd1;
            tick();
        end
        slot_valid = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        reset = 1'b1;
        trc_on = 1'b1;
        slot_valid = 1'b1;
        slot_data = 3'd5;
        flush_req = 1'b0;
        end_req = 1'b0;
        tm_wr_ready = 1'b1;

        vecs[0]  = mk(1, 1, 3'd1, 0, 1, 1, 0, 4'd1,  30'o1,          7'd0);
        vecs[1]  = mk(1, 1, 3'd2, 0, 1, 1, 0, 4'd2,  30'o12,         7'd0);
        vecs[2]  = mk(1, 1, 3'd3, 0, 1, 1, 0, 4'd3,  30'o123,        7'd0);
        vecs[3]  = mk(1, 1, 3'd4, 0, 1, 1, 0, 4'd4,  30'o1234,       7'd0);
        vecs[4]  = mk(1, 1, 3'd5, 0, 1, 1, 0, 4'd5,  30'o12345,      7'd0);
        vecs[5]  = mk(1, 1, 3'd6, 0, 1, 1, 0, 4'd6,  30'o123456,     7'd0);
        vecs[6]  = mk(1, 1, 3'd7, 0, 1, 1, 0, 4'd7,  30'o1234567,    7'd0);
        vecs[7]  = mk(1, 1, 3'd0, 0, 1, 1, 0, 4'd8,  30'o12345670,   7'd0);
        vecs[8]  = mk(1, 1, 3'd1, 0, 1, 1, 0, 4'd9,  30'o123456701,  7'd0);
        vecs[9]  = mk(1, 1, 3'd2, 0, 1, 1, 1, 4'd10, 30'o1234567012, 7'd0);
        vecs[10] = mk(1, 0, 3'd0, 0, 1, 0, 0, 4'd0,  30'o0,          7'd1);
        vecs[11] = mk(1, 0, 3'd0, 0, 1, 1, 0, 4'd0,  30'o0,          7'd1);
        vecs[12] = mk(1, 1, 3'd5, 0, 1, 1, 0, 4'd1,  30'o5,          7'd1);
        vecs[13] = mk(1, 1, 3'd6, 0, 1, 1, 0, 4'd2,  30'o56,         7'd1);
        vecs[14] = mk(1, 1, 3'd7, 0, 1, 1, 0, 4'd3,  30'o567,        7'd1);
        vecs[15] = mk(1, 0, 3'd0, 1, 0, 1, 1, 4'd3,  30'o567,        7'd1);
        vecs[16] = mk(1, 0, 3'd0, 0, 0, 0, 1, 4'd3,  30'o567,        7'd1);
        vecs[17] = mk(1, 0, 3'd0, 1, 0, 0, 1, 4'd3,  30'o567,        7'd1);
        vecs[18] = mk(1, 1, 3'd2, 0, 0, 0, 1, 4'd3,  30'o567,        7'd1);
        vecs[19] = mk(1, 0, 3'd0, 0, 0, 0, 1, 4'd3,  30'o567,        7'd1);
        vecs[20] = mk(1, 0, 3'd0, 0, 0, 0, 1, 4'd3,  30'o567,        7'd1);
        vecs[21] = mk(1, 0, 3'd0, 0, 1, 0, 0, 4'd0,  30'o0,          7'd2);
        vecs[22] = mk(1, 0, 3'd0, 1, 1, 1, 0, 4'd0,  30'o0,          7'd2);
        vecs[23] = mk(0, 1, 3'd3, 0, 1, 0, 0, 4'd0,  30'o0,          7'd2);
        vecs[24] = mk(1, 1, 3'd4, 1, 0, 1, 1, 4'd1,  30'o4,          7'd2);
        vecs[25] = mk(1, 0, 3'd0, 0, 1, 0, 0, 4'd0,  30'o0,          7'd3);

        #1 chk_all_zero("reset");
        tick();
        tick();
        reset = 1'b0;
        slot_valid = 1'b0;

        foreach (vecs[i]) begin
            trc_on = vecs[i].trc;
            slot_valid = vecs[i].sv;
            slot_data = vecs[i].sd;
            flush_req = vecs[i].fl;
            tm_wr_ready = vecs[i].rdy;
            #1 chk($sformatf("v%0d_slot_ready", i), 64'(slot_ready), 64'(vecs[i].e_sr));
            tick();
            chk($sformatf("v%0d_valid", i), 64'(tm_wr_valid), 64'(vecs[i].e_valid));
            chk($sformatf("v%0d_count", i), 64'(dct_count), 64'(vecs[i].e_cnt));
            chk($sformatf("v%0d_buffer", i), 64'(dct_buffer), 64'(vecs[i].e_buf));
            chk($sformatf("v%0d_data", i), 64'(tm_wr_data), 64'({vecs[i].e_cnt, vecs[i].e_buf}));
            chk($sformatf("v%0d_addr", i), 64'(tm_wr_addr), 64'(vecs[i].e_addr));
        end
        flush_req = 1'b0;
        slot_valid = 1'b0;
        trc_on = 1'b1;

        // End request with two slots buffered, second slot arriving with end_req.
        tm_wr_ready = 1'b0;
        slot_valid = 1'b1; slot_data = 3'd3;
        tick();
        slot_data = 3'd1; end_req = 1'b1;
        #1 chk("end_same_cycle_ready", 64'(slot_ready), 64'd1);
        tick();
        end_req = 1'b0;
        chk("end_ending_next", 64'(test_ending), 64'd1);
        chk("end_not_ended", 64'(test_has_ended), 64'd0);
        chk("end_count_kept", 64'(dct_count), 64'd2);
        chk("end_ready_blocked", 64'(slot_ready), 64'd0);
        tick();
        slot_valid = 1'b0;
        chk("end_final_valid", 64'(tm_wr_valid), 64'd1);
        chk("end_final_data", 64'(tm_wr_data), 64'({4'd2, 30'o31}));
        chk("end_final_addr", 64'(tm_wr_addr), 64'd3);
        tm_wr_ready = 1'b1;
        tick();
        chk("end_has_ended", 64'(test_has_ended), 64'd1);
        chk("end_ending_held", 64'(test_ending), 64'd1);
        chk("end_valid_drop", 64'(tm_wr_valid), 64'd0);
        chk("end_addr_inc", 64'(tm_wr_addr), 64'd4);
        chk("end_state", 64'(dbg_state), 64'd2);
        slot_valid = 1'b1; flush_req = 1'b1; end_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("ended_ready_%0d", k), 64'(slot_ready), 64'd0);
            tick();
            chk($sformatf("ended_sticky_%0d", k), 64'(test_has_ended), 64'd1);
            chk($sformatf("ended_no_write_%0d", k), 64'(tm_wr_valid), 64'd0);
            chk($sformatf("ended_count_%0d", k), 64'(dct_count), 64'd0);
        end

        // End request with nothing buffered goes straight to ENDED.
        async_reset("rst_from_ended");
        end_req = 1'b1;
        tick();
        end_req = 1'b0;
        chk("end0_ending", 64'(test_ending), 64'd1);
        chk("end0_not_ended", 64'(test_has_ended), 64'd0);
        chk("end0_no_valid", 64'(tm_wr_valid), 64'd0);
        tick();
        chk("end0_has_ended", 64'(test_has_ended), 64'd1);
        chk("end0_no_write", 64'(tm_wr_valid), 64'd0);
        chk("end0_addr", 64'(tm_wr_addr), 64'd0);

        // Reset mid-frame and mid-EMIT, then a fresh capture starts at address 0.
        async_reset("rst_pre");
        send_frame(3'd7, 1'b1);
        tick();
        chk("rst_frame_addr", 64'(tm_wr_addr), 64'd1);
        for (int k = 0; k < 4; k++) begin
            slot_valid = 1'b1; slot_data = 3'd6;
            tick();
        end
        chk("rst_midframe_cnt", 64'(dct_count), 64'd4);
        async_reset("rst_midframe");
        send_frame(3'd0, 1'b1);
        tick();
        send_frame(3'd2, 1'b0);
        chk("rst_emit_valid", 64'(tm_wr_valid), 64'd1);
        chk("rst_emit_addr", 64'(tm_wr_addr), 64'd1);
        chk("rst_emit_state", 64'(dbg_state), 64'd1);
        async_reset("rst_midemit");
        send_frame(3'd1, 1'b1);
        chk("rst_after_valid", 64'(tm_wr_valid), 64'd1);
        chk("rst_after_addr", 64'(tm_wr_addr), 64'd0);
        chk("rst_after_data", 64'(tm_wr_data), 64'({4'd10, 30'o1234567012}));
        tick();

        // 129 frames: address wraps 127 -> 0 and tm_wrap becomes sticky.
        async_reset("rst_wrap");
        for (int f = 0; f < 129; f++) begin
            send_frame(3'(f), 1'b1);
            chk($sformatf("wrap_valid_f%0d", f), 64'(tm_wr_valid), 64'd1);
            chk($sformatf("wrap_addr_f%0d", f), 64'(tm_wr_addr), 64'(f % 128));
            chk($sformatf("wrap_flag_f%0d", f), 64'(tm_wrap), 64'(f >= 128));
            tick();
            chk($sformatf("wrap_done_f%0d", f), 64'(tm_wr_valid), 64'd0);
        end
        chk("wrap_final_flag", 64'(tm_wrap), 64'd1);
        chk("wrap_final_addr", 64'(tm_wr_addr), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
